frame_pingpong_buf: RTL and testbench
=====================================

FRAME_PINGPONG_BUF -- requirements
Module: frame_pingpong_buf

Interface
REQ-001 Parameter WORDS, 20, words per frame.
REQ-002 Parameter DW, 16, data word width.
REQ-003 Parameter AW, 5, address width, ceil(log2(WORDS)).
REQ-004 clk  input  1  system clock, all logic rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 wr_adr  input  AW  write address from the upstream address commutator.
REQ-007 we  input  1  write enable, level-sensitive, one write per cycle high.
REQ-008 wr_data  input  DW  word to store.
REQ-009 full  input  1  frame-complete indication from the commutator, one or more cycles high.
REQ-010 rd_ready  input  1  downstream accepts the current read word.
REQ-011 rd_data  output  DW  word being presented.
REQ-012 rd_valid  output  1  rd_data valid.
REQ-013 rd_last  output  1  high with the final word (index WORDS-1) of a frame.
REQ-014 busy  output  1  readout in progress.
REQ-015 frame_lost  output  1  one-cycle pulse, completed frame dropped.

Function
REQ-016 The block SHALL hold two banks of WORDS x DW; register wr_bank selects the bank written, rd_bank the bank read.
REQ-017 With we high and wr_adr < WORDS, bank[wr_bank][wr_adr] SHALL take wr_data at the clock edge; wr_adr >= WORDS SHALL be ignored.
REQ-018 full SHALL be registered and a rising edge detected; only the edge (one event per frame) SHALL act.
REQ-019 On a full edge with reader IDLE: rd_bank <= wr_bank, wr_bank toggles, rd_cnt <= 0, reader -> FETCH.
REQ-020 On a full edge with reader not IDLE: wr_bank unchanged, frame_lost pulses one cycle, the next frame overwrites the same bank.
REQ-021 A write in the same cycle as the acting full edge SHALL land in the pre-toggle bank.
REQ-022 Reader states: IDLE, FETCH, SEND.
REQ-023 FETCH: issue synchronous read of bank[rd_bank][rd_cnt]; next state SEND.
REQ-024 SEND: rd_valid=1, rd_data stable until rd_valid&&rd_ready; rd_last=1 iff rd_cnt==WORDS-1.
REQ-025 SEND handshake with rd_cnt==WORDS-1 -> IDLE; else rd_cnt+1 -> FETCH.
REQ-026 Latency: registered full edge at cycle N SHALL give first rd_valid at N+2; max throughput one word per 2 cycles.
REQ-027 busy SHALL equal (state != IDLE).
REQ-028 The reader SHALL never access the bank selected by wr_bank; writes during readout SHALL not disturb rd_data.
REQ-029 rd_cnt width AW, never exceeds WORDS-1, no wrap beyond.

Reset
REQ-030 On rst low: state IDLE, wr_bank 0, rd_bank 0, rd_cnt 0, full edge register 0.
REQ-031 On rst low: rd_valid, rd_last, busy, frame_lost 0; rd_data 0.
REQ-032 RAM contents SHALL not be reset; reset mid-readout SHALL abort the frame with no further rd_valid.

Structure
REQ-033 Package frame_buf_pkg SHALL hold WORDS, DW, AW defaults and the reader state encoding.
REQ-034 Sub-module frame_bank_ram (1 write port, 1 synchronous read port, WORDS x DW) SHALL be instantiated twice.

Verification
REQ-035 Write 0x1000+i at adr i (i=0..19), pulse full, rd_ready=1 -> 20 words 0x1000..0x1013 in order, rd_last only on 0x1013, first rd_valid 2 cycles after registered edge.
REQ-036 Hold rd_ready=0 for 5 cycles on word 3 -> rd_data stays 0x1003, rd_valid stays 1, no skip.
REQ-037 Second frame 0x2000+i written during readout of first -> first frame output unchanged; after second full, 0x2000..0x2013 read out.
REQ-038 full edge while busy -> frame_lost one-cycle pulse, wr_bank unchanged, current readout completes intact.
REQ-039 full held high 4 cycles -> exactly one readout started.
REQ-040 rst low at word 10 of readout -> rd_valid, busy 0 immediately; after release, new frame read from word 0.

Source files
------------

// File: rtl/frame_buf_pkg.sv
// Shared defaults and reader state encoding for the ping-pong frame buffer.
package frame_buf_pkg;

    localparam int unsigned WordsDef = 20;
    localparam int unsigned DwDef    = 16;
    localparam int unsigned AwDef    = 5;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StSend
    } rd_state_e;

endpackage

// File: rtl/frame_pingpong_buf_if.sv
// Write side from the address commutator plus the ready/valid read stream.
interface frame_pingpong_buf_if #(
    parameter int unsigned DW = frame_buf_pkg::DwDef,
    parameter int unsigned AW = frame_buf_pkg::AwDef
);

    logic [AW-1:0] wr_adr;
    logic          we;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_last;
    logic          busy;
    logic          frame_lost;

    modport master (
        output wr_adr, we, wr_data, full, rd_ready,
        input  rd_data, rd_valid, rd_last, busy, frame_lost
    );

    modport slave (
        input  wr_adr, we, wr_data, full, rd_ready,
        output rd_data, rd_valid, rd_last, busy, frame_lost
    );

endinterface

// File: rtl/frame_bank_ram.sv
// One frame bank: single write port, synchronous read port with a resettable output register.
module frame_bank_ram #(
    parameter int unsigned WORDS = 20,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] wr_adr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          re_i,
    input  logic [AW-1:0] rd_adr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [WORDS];
    logic [DW-1:0] rd_data_q;

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_adr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else if (re_i) begin
            rd_data_q <= mem_q[rd_adr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/frame_pingpong_buf.sv
// Ping-pong frame buffer: one bank fills from the commutator while the other streams out.
// A frame completing while the reader is still busy is dropped and its bank is reused.
module frame_pingpong_buf
    import frame_buf_pkg::*;
#(
    parameter int unsigned WORDS = WordsDef,
    parameter int unsigned DW    = DwDef,
    parameter int unsigned AW    = AwDef
) (
    input  logic                clk,
    input  logic                rst,
    frame_pingpong_buf_if.slave bus_io
);

    rd_state_e     state_q, state_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic          full_q;
    logic          frame_lost_q, frame_lost_d;
    logic          full_rise;
    logic          wr_ok;
    logic          rd_req;
    logic          cnt_at_last;
    logic [DW-1:0] bank_rdata [2];

    // One extra bit so WORDS == 2**AW still compares correctly.
    assign full_rise   = bus_io.full && !full_q;
    assign wr_ok       = bus_io.we && ({1'b0, bus_io.wr_adr} < (AW + 1)'(WORDS));
    assign cnt_at_last = (rd_cnt_q == AW'(WORDS - 1));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        frame_bank_ram #(
            .WORDS (WORDS),
            .DW    (DW),
            .AW    (AW)
        ) u_ram (
            .clk       (clk),
            .rst       (rst),
            .we_i      (wr_ok && (wr_bank_q == 1'(b))),
            .wr_adr_i  (bus_io.wr_adr),
            .wr_data_i (bus_io.wr_data),
            .re_i      (rd_req && (rd_bank_q == 1'(b))),
            .rd_adr_i  (rd_cnt_q),
            .rd_data_o (bank_rdata[b])
        );
    end

    always_comb begin
        state_d      = state_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        rd_cnt_d     = rd_cnt_q;
        frame_lost_d = 1'b0;
        rd_req       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (full_rise) begin
                    rd_bank_d = wr_bank_q;
                    wr_bank_d = !wr_bank_q;
                    rd_cnt_d  = '0;
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                rd_req  = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (bus_io.rd_ready) begin
                    if (cnt_at_last) begin
                        state_d = StIdle;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        state_d  = StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Reader still owns its bank, so the freshly completed frame is discarded.
        if (full_rise && (state_q != StIdle)) begin
            frame_lost_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            rd_cnt_q     <= '0;
            full_q       <= 1'b0;
            frame_lost_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            rd_cnt_q     <= rd_cnt_d;
            full_q       <= bus_io.full;
            frame_lost_q <= frame_lost_d;
        end
    end

    assign bus_io.rd_valid   = (state_q == StSend);
    assign bus_io.rd_last    = (state_q == StSend) && cnt_at_last;
    assign bus_io.busy       = (state_q != StIdle);
    assign bus_io.frame_lost = frame_lost_q;
    assign bus_io.rd_data    = bank_rdata[rd_bank_q];

endmodule

// File: tb/tb_frame_pingpong_buf.sv
// Bench for frame_pingpong_buf: directed frame sequences plus a randomized run against a
// frame-level reference model.
module tb_frame_pingpong_buf;

    localparam int unsigned WORDS = 20;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    frame_pingpong_buf_if #(.DW(DW), .AW(AW)) bus ();

    frame_pingpong_buf #(
        .WORDS (WORDS),
        .DW    (DW),
        .AW    (AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t bg_q[$];

    typedef struct {
        int unsigned   stall;
        logic [DW-1:0] off;
        logic          last;
    } vec_t;
    vec_t tbl[WORDS];

    typedef struct {
        logic [DW-1:0] data;
        bit            known;
    } exp_t;
    exp_t exp_q[$];

    logic [DW-1:0] mdl_mem   [2][WORDS];
    bit            mdl_known [2][WORDS];
    int unsigned   mdl_wr;
    bit            mdl_busy;
    bit            mdl_full_prev;
    bit            exp_lost;
    bit            hold_prev;
    logic [DW-1:0] prev_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle; background writes are fed one per cycle.
    task automatic tick();
        wr_t w;
        @(posedge clk);
        #1;
        if (bg_q.size() > 0) begin
            w           = bg_q.pop_front();
            bus.we      = 1'b1;
            bus.wr_adr  = w.adr;
            bus.wr_data = w.data;
        end else begin
            bus.we = 1'b0;
        end
    endtask

    task automatic write_frame(input logic [DW-1:0] base);
        for (int i = 0; i < int'(WORDS); i++) bg_q.push_back('{adr: AW'(i), data: base + DW'(i)});
        bg_q.push_back('{adr: AW'(20), data: 16'hdead});
        bg_q.push_back('{adr: AW'(31), data: 16'hbeef});
    endtask

    task automatic flush_writes();
        while (bg_q.size() > 0) tick();
        tick();
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.rd_valid && n < 10) begin
            tick();
            n++;
        end
        chk("wait_rd_valid", bus.rd_valid, 1'b1);
    endtask

    task automatic read_frame(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wait_valid();
            chk("rd_data", bus.rd_data, base + tbl[i].off);
            chk("rd_last", bus.rd_last, tbl[i].last);
            for (int s = 0; s < int'(tbl[i].stall); s++) begin
                tick();
                chk("stall_valid", bus.rd_valid, 1'b1);
                chk("stall_data", bus.rd_data, base + tbl[i].off);
            end
            bus.rd_ready = 1'b1;
            tick();
            bus.rd_ready = 1'b0;
        end
    endtask

    task automatic start_frame();
        bus.full = 1'b1;
        tick();
        bus.full = 1'b0;
        chk("lat_fetch_no_valid", bus.rd_valid, 1'b0);
        chk("busy_after_edge", bus.busy, 1'b1);
        tick();
        chk("lat_first_valid", bus.rd_valid, 1'b1);
    endtask

    task automatic rand_step(input bit rnd);
        bit   rise;
        exp_t e;
        chk("rnd_busy", bus.busy, mdl_busy);
        chk("rnd_frame_lost", bus.frame_lost, exp_lost);
        if (bus.rd_valid) chk("rnd_valid_while_idle", mdl_busy, 1'b1);
        if (hold_prev) begin
            chk("rnd_hold_valid", bus.rd_valid, 1'b1);
            chk("rnd_hold_data", bus.rd_data, prev_data);
        end
        if (rnd) begin
            bus.we       = ($urandom_range(0, 9) < 7);
            bus.wr_adr   = AW'($urandom_range(0, 23));
            bus.wr_data  = DW'($urandom);
            bus.full     = bus.full ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
            bus.rd_ready = ($urandom_range(0, 9) < 6);
        end else begin
            bus.we       = 1'b0;
            bus.full     = 1'b0;
            bus.rd_ready = 1'b1;
        end
        // Effects of the coming clock edge, at frame granularity.
        rise     = bus.full && !mdl_full_prev;
        exp_lost = rise && mdl_busy;
        if (bus.we && (int'(bus.wr_adr) < int'(WORDS))) begin
            mdl_mem[mdl_wr][bus.wr_adr]   = bus.wr_data;
            mdl_known[mdl_wr][bus.wr_adr] = 1'b1;
        end
        if (rise && !mdl_busy) begin
            for (int i = 0; i < int'(WORDS); i++)
                exp_q.push_back('{data: mdl_mem[mdl_wr][i], known: mdl_known[mdl_wr][i]});
            mdl_wr   = 1 - mdl_wr;
            mdl_busy = 1'b1;
        end
        if (bus.rd_valid && bus.rd_ready) begin
            if (exp_q.size() == 0) begin
                chk("rnd_unexpected_word", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                if (e.known) chk("rnd_data", bus.rd_data, e.data);
                chk("rnd_last", bus.rd_last, exp_q.size() == 0);
                if (exp_q.size() == 0) mdl_busy = 1'b0;
            end
        end
        hold_prev     = bus.rd_valid && !bus.rd_ready;
        prev_data     = bus.rd_data;
        mdl_full_prev = bus.full;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(WORDS); i++) begin
            tbl[i].stall = (i == 3) ? 5 : 0;
            tbl[i].off   = DW'(i);
            tbl[i].last  = (i == int'(WORDS) - 1);
        end
        bus.we       = 1'b0;
        bus.wr_adr   = '0;
        bus.wr_data  = '0;
        bus.full     = 1'b0;
        bus.rd_ready = 1'b0;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_valid", bus.rd_valid, 1'b0);
        chk("rst_rd_last", bus.rd_last, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_frame_lost", bus.frame_lost, 1'b0);
        chk("rst_rd_data", bus.rd_data, 16'h0000);
        rst = 1'b1;
        tick();

        // Frame 1 with a stall on word 3; frame 2 is written underneath it.
        write_frame(16'h1000);
        flush_writes();
        start_frame();
        write_frame(16'h2000);
        read_frame(16'h1000, WORDS);
        chk("idle_after_frame1", bus.busy, 1'b0);
        flush_writes();

        // Frame 2 readout; frame 3 completes mid-readout and is dropped.
        start_frame();
        write_frame(16'h3000);
        fork
            read_frame(16'h2000, WORDS);
            begin
                repeat (30) @(posedge clk);
                #2 bus.full = 1'b1;
                @(posedge clk);
                #2;
                chk("lost_pulse", bus.frame_lost, 1'b1);
                chk("busy_on_lost", bus.busy, 1'b1);
                bus.full = 1'b0;
                @(posedge clk);
                #2;
                chk("lost_one_cycle", bus.frame_lost, 1'b0);
            end
        join
        chk("idle_after_frame2", bus.busy, 1'b0);

        // Dropped frame left the write bank alone, so frame 3 reads out now; full held 4 cycles.
        bus.full = 1'b1;
        tick();
        chk("held_fetch_no_valid", bus.rd_valid, 1'b0);
        chk("held_lost0", bus.frame_lost, 1'b0);
        tick();
        chk("held_first_valid", bus.rd_valid, 1'b1);
        chk("held_lost1", bus.frame_lost, 1'b0);
        tick();
        chk("held_lost2", bus.frame_lost, 1'b0);
        tick();
        chk("held_lost3", bus.frame_lost, 1'b0);
        bus.full = 1'b0;
        tick();
        chk("held_lost4", bus.frame_lost, 1'b0);
        read_frame(16'h3000, WORDS);
        repeat (4) tick();
        chk("single_readout_busy", bus.busy, 1'b0);
        chk("single_readout_valid", bus.rd_valid, 1'b0);

        // Reset while word 10 is presented.
        write_frame(16'h5000);
        flush_writes();
        start_frame();
        read_frame(16'h5000, 10);
        wait_valid();
        chk("word10_data", bus.rd_data, 16'h500a);
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", bus.rd_valid, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_last", bus.rd_last, 1'b0);
        chk("midrst_data", bus.rd_data, 16'h0000);
        tick();
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("postrst_valid", bus.rd_valid, 1'b0);
        chk("postrst_busy", bus.busy, 1'b0);
        write_frame(16'h6000);
        flush_writes();
        start_frame();
        read_frame(16'h6000, WORDS);

        // Randomized traffic against the frame-level model.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        mdl_wr        = 0;
        mdl_busy      = 1'b0;
        mdl_full_prev = 1'b0;
        exp_lost      = 1'b0;
        hold_prev     = 1'b0;
        prev_data     = '0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < int'(WORDS); i++) begin
                mdl_known[b][i] = 1'b0;
                mdl_mem[b][i]   = '0;
            end
        for (int n = 0; n < 3000; n++) rand_step(1'b1);
        for (int n = 0; n < 300 && (mdl_busy || bus.busy); n++) rand_step(1'b0);
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_busy", bus.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
